// File: rtl/io_out_serializer.sv
// io_out_serializer: buffers core output-port words in a small FIFO and streams
// each word out as four bytes, least-significant byte first, over valid/ready.
module io_out_serializer #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [DATA_W-1:0]      wr_data,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   byte_valid,
  output logic [7:0]             byte_data,
  output logic                   byte_last,
  input  logic                   byte_ready,
  output logic                   overflow,
  input  logic                   clr_ovf
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic [CNT_W-1:0]  count_next_s;
  logic              full_r;
  logic              overflow_r;
  state_t            state_r;
  state_t            state_next_s;
  logic [DATA_W-1:0] shreg_r;
  logic [DATA_W-1:0] shreg_next_s;
  logic [1:0]        byte_cnt_r;
  logic [1:0]        byte_cnt_next_s;
  logic              byte_last_r;
  logic              pop_s;
  logic              push_s;
  logic              drop_s;

  // A pop frees a slot in the same cycle, so a full FIFO can still accept a word.
  assign push_s = wr_en & ((count_r != DEPTH_C) | pop_s);
  assign drop_s = wr_en & ~push_s;

  assign full       = full_r;
  assign count      = count_r;
  assign overflow   = overflow_r;
  assign byte_valid = (state_r == SEND);
  assign byte_data  = shreg_r[7:0];
  assign byte_last  = byte_last_r;

  // Serializer next-state: load from FIFO head, shift on accept, reload back-to-back.
  always_comb begin
    state_next_s    = state_r;
    shreg_next_s    = shreg_r;
    byte_cnt_next_s = byte_cnt_r;
    pop_s           = 1'b0;
    case (state_r)
      IDLE: begin
        if (count_r != {CNT_W{1'b0}}) begin
          pop_s           = 1'b1;
          shreg_next_s    = mem_r[rd_ptr_r];
          byte_cnt_next_s = 2'd0;
          state_next_s    = SEND;
        end else begin
          state_next_s = IDLE;
        end
      end
      SEND: begin
        if (byte_ready) begin
          if (byte_cnt_r != 2'd3) begin
            shreg_next_s    = {8'h00, shreg_r[DATA_W-1:8]};
            byte_cnt_next_s = byte_cnt_r + 2'd1;
          end else if (count_r != {CNT_W{1'b0}}) begin
            pop_s           = 1'b1;
            shreg_next_s    = mem_r[rd_ptr_r];
            byte_cnt_next_s = 2'd0;
          end else begin
            state_next_s = IDLE;
          end
        end else begin
          state_next_s = SEND;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Occupancy update from this cycle's push/pop pair.
  always_comb begin
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_W'(1);
      2'b01:   count_next_s = count_r - CNT_W'(1);
      default: count_next_s = count_r;
    endcase
  end

  // FIFO storage; contents are meaningless while count is zero, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Control, pointer, serializer and sticky-flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      shreg_r     <= {DATA_W{1'b0}};
      byte_cnt_r  <= 2'd0;
      byte_last_r <= 1'b0;
      wr_ptr_r    <= {PTR_W{1'b0}};
      rd_ptr_r    <= {PTR_W{1'b0}};
      count_r     <= {CNT_W{1'b0}};
      full_r      <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      shreg_r     <= shreg_next_s;
      byte_cnt_r  <= byte_cnt_next_s;
      byte_last_r <= (state_next_s == SEND) && (byte_cnt_next_s == 2'd3);
      count_r     <= count_next_s;
      full_r      <= (count_next_s == DEPTH_C);
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      // A drop in the same cycle as a clear must leave the flag set.
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else if (clr_ovf) begin
        overflow_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_io_out_serializer.sv
// Testbench for io_out_serializer: directed scenarios plus random traffic,
// checked each cycle against a word-queue reference model.
module tb_io_out_serializer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [31:0] wr_data = 32'h0;
  logic        full;
  logic [2:0]  count;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_last;
  logic        byte_ready = 1'b0;
  logic        overflow;
  logic        clr_ovf = 1'b0;

  int tests = 0;
  int fails = 0;

  // Reference model: queued words, the word being sent, and its byte index.
  logic [31:0] m_q[$];
  logic [31:0] m_word;
  int          m_idx;
  logic        m_busy;
  logic        m_ovf;
  logic [7:0]  cap_q[$];

  io_out_serializer #(.DEPTH(DEPTH), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .full(full),
    .count(count), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_last(byte_last), .byte_ready(byte_ready), .overflow(overflow),
    .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_word = 32'h0;
    m_idx  = 0;
    m_busy = 1'b0;
    m_ovf  = 1'b0;
  endtask

  task automatic check_outputs();
    chk("byte_valid", {31'h0, byte_valid}, {31'h0, m_busy});
    chk("byte_last", {31'h0, byte_last}, {31'h0, (m_busy && m_idx == 3)});
    chk("count", {29'h0, count}, 32'(m_q.size()));
    chk("full", {31'h0, full}, {31'h0, (m_q.size() == DEPTH)});
    chk("overflow", {31'h0, overflow}, {31'h0, m_ovf});
    if (m_busy) chk("byte_data", {24'h0, byte_data}, (m_word >> (8 * m_idx)) & 32'hFF);
  endtask

  // One clock cycle: drive inputs, check current outputs, advance model, clock.
  task automatic step(input logic we, input logic [31:0] wd, input logic rdy, input logic clr);
    logic pop;
    logic accept;
    wr_en = we; wr_data = wd; byte_ready = rdy; clr_ovf = clr;
    check_outputs();
    if (byte_valid && rdy) cap_q.push_back(byte_data);
    pop = (m_q.size() > 0) && (!m_busy || (rdy && m_idx == 3));
    accept = we && ((m_q.size() < DEPTH) || pop);
    if (m_busy && rdy && m_idx < 3) begin
      m_idx++;
    end else if (pop) begin
      m_word = m_q.pop_front();
      m_idx  = 0;
      m_busy = 1'b1;
    end else if (m_busy && rdy) begin
      m_busy = 1'b0;
    end
    if (accept) m_q.push_back(wd);
    if (we && !accept) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, rdy, 1'b0);
  endtask

  task automatic chk_stream(input string tag, input logic [7:0] exp[$]);
    chk({tag, "_len"}, 32'(cap_q.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < cap_q.size(); i++)
      chk(tag, {24'h0, cap_q[i]}, {24'h0, exp[i]});
    cap_q.delete();
  endtask

  initial begin
    logic [7:0] exp_q[$];
    model_reset();
    // Reset values
    #2;
    chk("rst_byte_data", {24'h0, byte_data}, 32'h0);
    check_outputs();
    @(posedge clk); #1;
    rst = 1'b0;

    // Single word, 2-edge latency, LSB first
    step(1'b1, 32'h11223344, 1'b1, 1'b0);
    idle(7, 1'b1);
    exp_q = '{8'h44, 8'h33, 8'h22, 8'h11};
    chk_stream("single", exp_q);

    // Two back-to-back words
    step(1'b1, 32'hAABBCCDD, 1'b1, 1'b0);
    step(1'b1, 32'h01020304, 1'b1, 1'b0);
    idle(10, 1'b1);
    exp_q = '{8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h04, 8'h03, 8'h02, 8'h01};
    chk_stream("pair", exp_q);

    // Overflow: six writes while stalled, word 5 dropped
    for (int w = 0; w < 6; w++) step(1'b1, 32'(w), 1'b0, 1'b0);
    chk("ovf_set", {31'h0, overflow}, 32'h1);
    chk("ovf_full", {31'h0, full}, 32'h1);
    idle(10, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    idle(14, 1'b1);
    chk("ovf_clr", {31'h0, overflow}, 32'h0);
    exp_q.delete();
    for (int w = 0; w < 5; w++) begin
      exp_q.push_back(8'(w));
      for (int b = 0; b < 3; b++) exp_q.push_back(8'h00);
    end
    chk_stream("ovf", exp_q);

    // Full FIFO with a pop coinciding with a write
    for (int w = 0; w < 5; w++) step(1'b1, 32'h10 + 32'(w), 1'b0, 1'b0);
    idle(3, 1'b1);
    step(1'b1, 32'h55, 1'b1, 1'b0);
    idle(3, 1'b0);
    chk("coinc_count", {29'h0, count}, 32'd4);
    chk("coinc_ovf", {31'h0, overflow}, 32'h0);
    idle(24, 1'b1);
    chk("coinc_last", {24'h0, cap_q[cap_q.size() - 4]}, 32'h55);
    cap_q.delete();

    // Stall while byte 0x33 is presented
    step(1'b1, 32'h11223344, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    idle(5, 1'b0);
    chk("stall_hold", {24'h0, byte_data}, 32'h33);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("stall_next", {24'h0, byte_data}, 32'h22);
    idle(4, 1'b1);
    cap_q.delete();

    // Reset mid-word with two words queued
    step(1'b1, 32'h11223344, 1'b0, 1'b0);
    step(1'b1, 32'hCAFEF00D, 1'b0, 1'b0);
    step(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    model_reset();
    chk("midrst_byte_data", {24'h0, byte_data}, 32'h0);
    check_outputs();
    @(posedge clk); #1;
    rst = 1'b0;
    idle(6, 1'b1);
    cap_q.delete();
    step(1'b1, 32'h87654321, 1'b1, 1'b0);
    idle(6, 1'b1);
    exp_q = '{8'h21, 8'h43, 8'h65, 8'h87};
    chk_stream("post_rst", exp_q);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      logic [31:0] rd;
      rd = $urandom;
      step(($urandom_range(0, 99) < ((i < 300) ? 45 : 20)) ? 1'b1 : 1'b0, rd,
           ($urandom_range(0, 99) < ((i < 300) ? 60 : 100)) ? 1'b1 : 1'b0,
           ($urandom_range(0, 99) < 4) ? 1'b1 : 1'b0);
    end
    idle(30, 1'b1);
    check_outputs();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/io_out_serializer.md
# io_out_serializer

Output-port stage sitting directly downstream of the single-cycle RISC-V core. Each cycle the core strobes a store to its output port, this block captures the 32-bit register value into a small FIFO. It then drains each word as four bytes, least-significant byte first, over a valid/ready byte stream toward a UART transmitter or display driver. It decouples the core's one-word-per-cycle output rate from a slow byte consumer and flags any words lost to overflow.

## Interface
- DEPTH, 4, FIFO depth in words; power of two, ≥2
- DATA_W, 32, word width; fixed at 32, four bytes per word
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- wr_en  input  1  core output strobe (core OutputSRC), one word per high cycle
- wr_data  input  32  word to emit (core RD2), signed value treated as raw bits
- full  output  1  FIFO holds DEPTH words
- count  output  $clog2(DEPTH)+1  words currently in FIFO, excluding the word in the shifter
- byte_valid  output  1  byte_data is valid
- byte_data  output  8  current byte
- byte_last  output  1  current byte is byte 3 (MSB) of its word
- byte_ready  input  1  consumer accepts byte when high with byte_valid
- overflow  output  1  sticky: at least one word dropped
- clr_ovf  input  1  synchronous clear of overflow

## Operation
- FIFO: circular buffer, wr_ptr/rd_ptr wrap modulo DEPTH, count register.
- Write accepted when wr_en=1 and (count<DEPTH or pop in same cycle); accepted word stored at wr_ptr, wr_ptr++.
- Write with wr_en=1, count=DEPTH, no pop that cycle: word dropped, FIFO unchanged, overflow set next edge.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- overflow: set by drop, cleared by clr_ovf. Drop and clr_ovf in the same cycle leaves overflow=1 (set wins).
- Serializer FSM, 2 states:
  - IDLE: byte_valid=0. If count>0, pop the head into a 32-bit shift register, set byte_cnt=0, and move to SEND.
  - SEND: byte_valid=1, byte_data=shreg[7:0], byte_last=(byte_cnt==3).
  - SEND, on byte_ready while byte_cnt<3: shreg>>=8 and byte_cnt++.
  - SEND, on byte_ready while byte_cnt==3: if count>0, pop the next word, reload, and set byte_cnt=0, staying in SEND. Otherwise go to IDLE.
- byte_data/byte_last stable while byte_valid=1 and byte_ready=0.
- count reflects only the FIFO; the word being shifted is no longer counted.

## Timing
- Reset (async assert, sync-safe deassert): state=IDLE, pointers=0, count=0, full=0, overflow=0, byte_valid=0, byte_data=0, byte_last=0, shreg=0.
- Reset mid-transfer aborts the word: remaining bytes and all FIFO contents are discarded.
- Latency: word written at edge k → count=1 after k → popped at edge k+1 → byte_valid=1 after edge k+1 (2 edges write-to-first-byte).
- With byte_ready held 1 and FIFO non-empty, bytes stream with no bubbles: 4 cycles per word, back-to-back across words.
- full and count are registered and update on the edge after the push/pop.
- Core may write every cycle; sustained rate above 1 word/4 cycles overflows after DEPTH plus one in-flight word.

## Test plan
- Reset then write 0x11223344 once, byte_ready=1: byte_valid high 4 cycles starting 2 edges after the write, bytes 0x44,0x33,0x22,0x11, byte_last=1 only on 0x11, then IDLE.
- Writes 0xAABBCCDD and 0x01020304 on consecutive cycles, byte_ready=1: 8 contiguous valid bytes DD,CC,BB,AA,04,03,02,01, byte_last on AA and 01, overflow=0.
- byte_ready=0, write 6 words 0..5 (DEPTH=4): word 0 in shifter, words 1–4 fill FIFO (count=4, full=1), word 5 dropped, overflow=1. Then byte_ready=1 emits words 0–4 only; clr_ovf pulse clears overflow.
- FIFO full, byte_ready toggled so a pop coincides with wr_en=1 (word 0x55): write accepted, count stays 4, overflow stays 0, 0x55 emitted last.
- Stall: byte_ready=0 for 5 cycles while byte 1 (0x33 of 0x11223344) is presented: byte_data holds 0x33, byte_valid=1. Release → 0x22 the next cycle.
- Assert rst mid-word after byte 0x44 with 2 words queued: outputs go to reset values immediately, count=0. After release, no bytes emitted until a new write.
